frac_clk_div: RTL and testbench
===============================

Name: frac_clk_div

Overview:
- Phase-accumulator fractional clock divider.
- Derives a low-jitter-tolerant square wave of frequency f_clkin × div / 2^WIDTH from a fast reference clock.
- Sits between the 100 MHz system PLL output and the downstream emulation PLL, where it generates the ~21.477 MHz (NTSC) or ~21.281 MHz (PAL) master-clock reference.
- The div word is selected at top level, e.g. 922441723 for NTSC and 914027882 for PAL.

Parameters:
- WIDTH, 32: accumulator and div word width in bits.

Ports:
- clkin, input, 1: reference clock; all logic is on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- div, input, WIDTH: frequency control word. Output frequency = f_clkin × div / 2^WIDTH. Quasi-static; may change at any time.
- clkout, input/output: output, 1, registered divided clock = accumulator MSB.

Behaviour:
- State registers:
  - acc [WIDTH-1:0], the phase accumulator.
  - inc [WIDTH-1:0], the active increment.
  - loaded, 1 bit.
  - clkout, the output register.
- Reset (reset_n low, asynchronous, takes effect immediately without waiting for a clock edge):
  - acc = 0, inc = 0, loaded = 0, clkout = 0.
  - Held for as long as reset_n is low.
- Reset release is synchronous in effect: nothing changes until the first rising clkin edge with reset_n high.
- Per rising clkin edge with reset_n high:
  - clkout <= acc[WIDTH-1], i.e. the MSB of acc before this edge's update.
  - If loaded = 0:
    - inc <= div, loaded <= 1.
    - acc holds, so it is still 0 after this edge.
  - Else:
    - Form sum = acc + inc, computed WIDTH+1 bits wide.
    - acc <= sum[WIDTH-1:0], wrapping modulo 2^WIDTH.
    - carry = sum[WIDTH].
    - If carry = 1: inc <= div. This is the new-word pickup point.
    - If carry = 0: inc holds.
- div change rule: a new div takes effect only on the cycle after an accumulator wrap, so a change never truncates a partial phase. Changes between wraps are ignored except for the div value present at the wrap edge.
- Startup timing after reset release:
  - Edge 1: loads inc.
  - Edge 2: acc = div.
  - clkout first reflects accumulated phase at edge 3.
- div = 0: acc stays 0, carry never occurs, clkout stays 0, and inc never reloads. Recovery from div = 0 requires a reset. This is an accepted limitation.
- Timing:
  - Output duty cycle approaches 50% on average.
  - Each edge is quantised to clkin periods, giving jitter of up to 1 clkin period.
  - The downstream PLL filters this jitter.
- Average frequency: over N cycles, the number of clkout rising edges = floor(N × inc / 2^WIDTH) ± 1.
- Constraints:
  - No combinational path from div to clkout.
  - clkout is driven directly from a flop.
- Mid-operation reset: clkout drops to 0 asynchronously and acc clears. On release, the startup sequence repeats and the current div is loaded.

Test Plan:
1. Reset then div = 32'h8000_0000 → from edge 3 after release, clkout alternates every cycle (0,1,0,1,…, 50 MHz at 100 MHz clkin); acc sequence is 0, 8000_0000, 0, 8000_0000…
2. div = 32'h4000_0000 → clkout pattern 0,0,1,1 repeating (period 4, 50% duty); carry asserts every 4th update.
3. div = 922441723 for 1,000,000 clkin cycles → count of clkout rising edges is 214772 ± 1. Then div = 914027882 → the new rate applies only after the next acc wrap, and over 1,000,000 cycles the count is 212813 ± 1.
4. Running with div = 32'h4000_0000, change div to 32'h8000_0000 mid-phase (acc = 4000_0000) → acc keeps stepping by 4000_0000 until wrap to 0, then steps by 8000_0000.
5. div = 0 after reset → clkout is constant 0 for 1000 cycles and acc is constant 0.
6. Assert reset_n low asynchronously between edges while clkout = 1 → clkout is 0 before the next clkin edge. Release with div = 32'h8000_0000 → scenario 1 sequence restarts from acc = 0.

Source files
------------

// File: rtl/frac_clk_div_if.sv
// Bus between the top-level rate selector and the fractional clock divider.
// div is a quasi-static control word with no handshake: the divider samples it only at
// startup and at accumulator wraps. clkout and the dbg_* taps are driven by the divider.
interface frac_clk_div_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] div;
  logic             clkout;
  logic [WIDTH-1:0] dbg_acc;
  logic [WIDTH-1:0] dbg_inc;
  logic             dbg_loaded;

  modport master (
    output div,
    input  clkout,
    input  dbg_acc,
    input  dbg_inc,
    input  dbg_loaded
  );

  modport slave (
    input  div,
    output clkout,
    output dbg_acc,
    output dbg_inc,
    output dbg_loaded
  );
endinterface

// File: rtl/frac_clk_div.sv
// Phase-accumulator fractional clock divider: clkout averages f_clkin * div / 2^WIDTH.
// The increment is reloaded only at a wrap, so a div change never truncates a phase.
module frac_clk_div #(
  parameter int WIDTH = 32
) (
  input  logic            clkin,
  input  logic            reset_n,
  frac_clk_div_if.slave   bus
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] inc_q, inc_d;
  logic             clkout_q;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_LOAD;
      acc_q    <= '0;
      inc_q    <= '0;
      clkout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      // Output is the pre-update phase MSB, so clkout never depends on div combinationally.
      clkout_q <= acc_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    case (state_q)
      ST_LOAD: begin
        inc_d   = bus.div;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        acc_d = sum[WIDTH-1:0];
        // The carry out marks the wrap: the only point a new div is picked up.
        if (sum[WIDTH]) begin
          inc_d = bus.div;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign bus.clkout     = clkout_q;
  assign bus.dbg_acc    = acc_q;
  assign bus.dbg_inc    = inc_q;
  assign bus.dbg_loaded = (state_q == ST_RUN);

endmodule

// File: tb/tb_frac_clk_div.sv
// Directed bench for frac_clk_div: startup tables, div pickup at wrap, rate counts,
// div = 0 lockup and asynchronous mid-run reset.
module tb_frac_clk_div;

  localparam int W = 32;
  localparam logic [31:0] DIV_NTSC = 32'd922441723;
  localparam logic [31:0] DIV_PAL  = 32'd914027882;
  localparam int N_RATE = 20000;

  logic clkin   = 1'b0;
  logic reset_n = 1'b0;

  frac_clk_div_if #(.WIDTH(W)) bus ();

  frac_clk_div #(.WIDTH(W)) dut (
    .clkin   (clkin),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock/reset
  always #5 clkin = ~clkin;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int vectors     = 0;
  int miscompares = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]       div;
    logic [7:0][31:0]  acc;   // acc after edges 8..1 (index 0 = edge 1)
    logic [7:0]        clk;   // clkout after edges 8..1 (bit 0 = edge 1)
  } vec_t;

  vec_t vecs [5];

  // driver tasks
  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Asserts reset between edges, holds it across one edge, releases with div applied.
  task automatic do_reset(input logic [31:0] d, input string tag);
    step();
    reset_n = 1'b0;
    #1;
    check32({tag, " rst clkout"}, {31'd0, bus.clkout}, 32'd0);
    check32({tag, " rst acc"}, bus.dbg_acc, 32'd0);
    bus.div = d;
    step();
    check32({tag, " rst inc"}, bus.dbg_inc, 32'd0);
    check32({tag, " rst loaded"}, {31'd0, bus.dbg_loaded}, 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    for (int i = 0; i < 8; i++) begin
      step();
      check32($sformatf("%s acc e%0d", tag, i + 1), bus.dbg_acc, v.acc[i]);
      check32($sformatf("%s clk e%0d", tag, i + 1), {31'd0, bus.clkout}, {31'd0, v.clk[i]});
    end
  endtask

  task automatic count_rises(input int n, output int cnt);
    logic prev;
    cnt  = 0;
    prev = bus.clkout;
    for (int i = 0; i < n; i++) begin
      step();
      if (!prev && bus.clkout) cnt++;
      prev = bus.clkout;
    end
  endtask

  task automatic check_rate(input logic [31:0] d, input int cnt, input string tag);
    longint unsigned prod;
    int exp_cnt;
    int diff;
    prod    = longint'(N_RATE) * longint'(d);
    exp_cnt = int'(prod >> 32);
    diff    = cnt - exp_cnt;
    vectors++;
    if (diff > 1 || diff < -1) begin
      miscompares++;
      $display("FAIL %s: got %0d rising edges expected %0d +/- 1", tag, cnt, exp_cnt);
    end
  endtask

  initial begin
    int cnt;
    int bad;
    int guard;

    vecs[0].div = 32'h8000_0000;
    vecs[0].acc = {32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0,
                   32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0};
    vecs[0].clk = 8'b0101_0100;
    vecs[1].div = 32'h4000_0000;
    vecs[1].acc = {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
                   32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[1].clk = 8'b1001_1000;
    vecs[2].div = 32'h6000_0000;
    vecs[2].acc = {32'hA000_0000, 32'h4000_0000, 32'hE000_0000, 32'h8000_0000,
                   32'h2000_0000, 32'hC000_0000, 32'h6000_0000, 32'h0};
    vecs[2].clk = 8'b0110_1000;
    vecs[3].div = 32'hFFFF_FFFF;
    vecs[3].acc = {32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'hFFFF_FFFC,
                   32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    vecs[3].clk = 8'b1111_1100;
    vecs[4].div = 32'h0;
    vecs[4].acc = '0;
    vecs[4].clk = 8'b0000_0000;

    bus.div = 32'h0;
    #1;
    check32("power-on clkout", {31'd0, bus.clkout}, 32'd0);
    check32("power-on acc", bus.dbg_acc, 32'd0);

    // Startup sequences from reset release.
    for (int k = 0; k < 5; k++) begin
      do_reset(vecs[k].div, $sformatf("vec%0d", k));
      run_seq(vecs[k], $sformatf("vec%0d", k));
    end

    // div change mid-phase: old step continues until the wrap.
    do_reset(32'h4000_0000, "midchg");
    step();
    step();
    check32("midchg acc e2", bus.dbg_acc, 32'h4000_0000);
    bus.div = 32'h8000_0000;
    step(); check32("midchg acc e3", bus.dbg_acc, 32'h8000_0000);
    check32("midchg inc e3", bus.dbg_inc, 32'h4000_0000);
    step(); check32("midchg acc e4", bus.dbg_acc, 32'hC000_0000);
    step(); check32("midchg acc e5", bus.dbg_acc, 32'h0);
    check32("midchg inc e5", bus.dbg_inc, 32'h8000_0000);
    step(); check32("midchg acc e6", bus.dbg_acc, 32'h8000_0000);
    step(); check32("midchg acc e7", bus.dbg_acc, 32'h0);

    // div = 0 locks the divider until reset, even if div later changes.
    do_reset(32'h0, "zero");
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.clkout !== 1'b0 || bus.dbg_acc !== 32'h0) bad++;
    end
    check32("zero stuck cycles", bad, 32'd0);
    bus.div = 32'h8000_0000;
    for (int i = 0; i < 50; i++) step();
    check32("zero no reload inc", bus.dbg_inc, 32'h0);
    check32("zero no reload acc", bus.dbg_acc, 32'h0);

    // Average rate, NTSC then PAL with pickup at the next wrap.
    do_reset(DIV_NTSC, "ntsc");
    for (int i = 0; i < 20; i++) step();
    count_rises(N_RATE, cnt);
    check_rate(DIV_NTSC, cnt, "ntsc rate");
    bus.div = DIV_PAL;
    guard = 0;
    while (bus.dbg_inc !== DIV_PAL && guard < 100) begin
      step();
      guard++;
    end
    check32("pal pickup seen", {31'd0, bus.dbg_inc === DIV_PAL}, 32'd1);
    check32("pal pickup at wrap", {31'd0, bus.dbg_acc < DIV_NTSC}, 32'd1);
    count_rises(N_RATE, cnt);
    check_rate(DIV_PAL, cnt, "pal rate");

    // Asynchronous reset while clkout is high, then restart with div = 8000_0000.
    do_reset(32'h8000_0000, "async");
    guard = 0;
    while (bus.clkout !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    check32("async clkout high", {31'd0, bus.clkout}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check32("async clkout dropped", {31'd0, bus.clkout}, 32'd0);
    check32("async acc cleared", bus.dbg_acc, 32'd0);
    step();
    reset_n = 1'b1;
    run_seq(vecs[0], "async restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
